// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: shared UART constants and transmitter state encodings
package uart_tx_buffered_pkg;
    localparam int UART_DATA_W = 8;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;
endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: valid/ready byte handshake between producer and transmitter
interface uart_tx_buffered_if;
    import uart_tx_buffered_pkg::*;
    logic                   tx_valid;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_ready;
    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO, head entry visible on dout without read latency
module uart_tx_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [UART_DATA_W-1:0]     din,
    input  logic                       pop,
    output logic [UART_DATA_W-1:0]     dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rp];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= wp + AW'(do_push);
            rp <= rp + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              baud_tick,
    uart_tx_buffered_if.slave bus,
    output logic              txd,
    output logic              busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    tx_state_t state, state_d;
    logic [UART_DATA_W-1:0] shreg, shreg_d, dout;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic txd_d, pop, full, empty;
    logic [CW-1:0] count;
`ifdef UART_TX_PARITY_EN
    logic parity, parity_d;
`endif
    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.tx_valid && bus.tx_ready),
        .din   (bus.tx_data),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign bus.tx_ready = !full;
    assign busy = (state != IDLE) || (count != '0);
    // STOP shares IDLE's pop path so queued bytes follow with exactly one stop bit
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        bit_cnt_d = bit_cnt;
        txd_d = txd;
        pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity;
`endif
        if (baud_tick) begin
            case (state)
                IDLE, STOP: begin
                    pop = !empty;
                    shreg_d = empty ? shreg : dout;
                    txd_d = empty;
                    state_d = empty ? IDLE : START;
`ifdef UART_TX_PARITY_EN
                    parity_d = empty ? parity : ^dout;
`endif
                end
                START: begin
                    txd_d = shreg[0];
                    bit_cnt_d = '0;
                    state_d = DATA;
                end
                DATA: begin
                    if (bit_cnt != 3'd7) begin
                        shreg_d = shreg >> 1;
                        txd_d = shreg[1];
                        bit_cnt_d = bit_cnt + 3'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd_d = parity;
                        state_d = PARITY;
`else
                        txd_d = 1'b1;
                        state_d = STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    txd_d = 1'b1;
                    state_d = STOP;
                end
`endif
                default: begin
                    txd_d = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            shreg <= '0;
            bit_cnt <= '0;
            txd <= 1'b1;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            bit_cnt <= bit_cnt_d;
            txd <= txd_d;
        end
    end
`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) parity <= 1'b0;
        else parity <= parity_d;
    end
`endif
endmodule
